// File: rtl/cv32e40px_x_result_arbiter.sv
// Merges per-coprocessor result channels onto the single X-interface result port.
// Round-robin by default; define CV32E40PX_X_RESULT_FIXED_PRIO_EN for lowest-index-wins.
module cv32e40px_x_result_arbiter #(
    parameter int unsigned NUM_COPROC  = 2,
    parameter int unsigned X_RFW_WIDTH = 32,
    parameter int unsigned X_ID_WIDTH  = 4,
    localparam int unsigned SRC_W      = (NUM_COPROC > 1) ? $clog2(NUM_COPROC) : 1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NUM_COPROC-1:0]             cp_result_valid_i,
    output logic [NUM_COPROC-1:0]             cp_result_ready_o,
    input  logic [NUM_COPROC*X_ID_WIDTH-1:0]  cp_result_id_i,
    input  logic [NUM_COPROC*X_RFW_WIDTH-1:0] cp_result_data_i,
    input  logic [NUM_COPROC*5-1:0]           cp_result_rd_i,
    input  logic [NUM_COPROC-1:0]             cp_result_we_i,
    output logic                              x_result_valid_o,
    input  logic                              x_result_ready_i,
    output logic [X_ID_WIDTH-1:0]             x_result_id_o,
    output logic [X_RFW_WIDTH-1:0]            x_result_data_o,
    output logic [4:0]                        x_result_rd_o,
    output logic                              x_result_we_o,
    output logic [SRC_W-1:0]                  x_result_src_o
);

    logic                   out_valid_q, out_valid_d;
    logic [X_ID_WIDTH-1:0]  id_q, id_d;
    logic [X_RFW_WIDTH-1:0] data_q, data_d;
    logic [4:0]             rd_q, rd_d;
    logic                   we_q, we_d;
    logic [SRC_W-1:0]       src_q, src_d;
`ifndef CV32E40PX_X_RESULT_FIXED_PRIO_EN
    logic [SRC_W-1:0]       rr_q, rr_d;
`endif

    logic             load;
    logic             gnt_found;
    logic [SRC_W-1:0] gnt_idx;
    logic [4:0]       sel_rd;
    int               cand;

    // Grants are withheld while reset is asserted so ready reads zero during reset.
    assign load = (~out_valid_q | x_result_ready_i) & ~rst_i;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int i = 0; i < int'(NUM_COPROC); i++) begin
`ifdef CV32E40PX_X_RESULT_FIXED_PRIO_EN
            cand = i;
`else
            cand = (int'(rr_q) + i) % int'(NUM_COPROC);
`endif
            if (!gnt_found && cp_result_valid_i[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = SRC_W'(cand);
            end
        end
    end

    always_comb begin
        cp_result_ready_o = '0;
        if (load && gnt_found) begin
            cp_result_ready_o[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        id_d        = id_q;
        data_d      = data_q;
        rd_d        = rd_q;
        we_d        = we_q;
        src_d       = src_q;
`ifndef CV32E40PX_X_RESULT_FIXED_PRIO_EN
        rr_d        = rr_q;
`endif
        sel_rd      = cp_result_rd_i[int'(gnt_idx)*5 +: 5];
        if (load) begin
            out_valid_d = gnt_found;
            if (gnt_found) begin
                id_d   = cp_result_id_i[int'(gnt_idx)*int'(X_ID_WIDTH) +: X_ID_WIDTH];
                data_d = cp_result_data_i[int'(gnt_idx)*int'(X_RFW_WIDTH) +: X_RFW_WIDTH];
                rd_d   = sel_rd;
                // x0 is hardwired zero, never report a write to it.
                we_d   = cp_result_we_i[gnt_idx] & (sel_rd != 5'd0);
                src_d  = gnt_idx;
`ifndef CV32E40PX_X_RESULT_FIXED_PRIO_EN
                rr_d   = SRC_W'((int'(gnt_idx) + 1) % int'(NUM_COPROC));
`endif
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            id_q        <= '0;
            data_q      <= '0;
            rd_q        <= '0;
            we_q        <= 1'b0;
            src_q       <= '0;
`ifndef CV32E40PX_X_RESULT_FIXED_PRIO_EN
            rr_q        <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            id_q        <= id_d;
            data_q      <= data_d;
            rd_q        <= rd_d;
            we_q        <= we_d;
            src_q       <= src_d;
`ifndef CV32E40PX_X_RESULT_FIXED_PRIO_EN
            rr_q        <= rr_d;
`endif
        end
    end

    assign x_result_valid_o = out_valid_q;
    assign x_result_id_o    = id_q;
    assign x_result_data_o  = data_q;
    assign x_result_rd_o    = rd_q;
    assign x_result_we_o    = we_q;
    assign x_result_src_o   = src_q;

endmodule
